spi_master_gen2: RTL and testbench

SPI_MASTER_GEN2 -- requirements
Module: spi_master_gen2

---
 rtl/spi_master_gen2_pkg.sv | 15 +
 rtl/spi_master_gen2_clk_gen.sv | 41 ++++
 rtl/spi_master_gen2.sv | 147 ++++++++++++++
 tb/tb_spi_master_gen2.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_gen2_pkg.sv
// spi_master_gen2_pkg: shared FSM state type and mode-field bit positions
// for the SPI master and its clock generator.
package spi_master_gen2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL
  } state_t;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_master_gen2_clk_gen.sv
// spi_clk_gen: divider counter that emits one tick per clk_div cycles,
// plus SCLK level and leading/trailing edge strobes during a transfer.
module spi_clk_gen
  import spi_master_gen2_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             Pclk,
  input  logic             Preset,
  input  logic             run,
  input  logic             xfer,
  input  logic             load,
  input  logic             cpol_in,
  input  logic             cpol,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             lead_edge,
  output logic             trail_edge,
  output logic             sclk
);

  logic [DIV_W-1:0] cnt;

  // cnt restarts on every tick, so div=1 ticks every cycle with cnt pinned at 0
  assign tick       = run && (cnt == div - DIV_W'(1));
  assign lead_edge  = xfer && tick && (sclk == cpol);
  assign trail_edge = xfer && tick && (sclk != cpol);

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      if (!run || tick) cnt <= '0;
      else              cnt <= cnt + DIV_W'(1);
      if (load)              sclk <= cpol_in;
      else if (xfer && tick) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_gen2.sv
// spi_master_gen2: SPI master with runtime mode, divider and chip select.
// Define SPI_MASTER_LSB_FIRST_EN to add a latched lsb_first bit-order port.
module spi_master_gen2
  import spi_master_gen2_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NUM_CS = 4,
  parameter  int DIV_W  = 8,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              Pclk,
  input  logic              Preset,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [1:0]        mode,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int ECW = $clog2(2 * DATA_W);
  localparam logic [ECW-1:0]  LAST_E  = ECW'(2 * DATA_W - 1);
  localparam logic [CS_W:0]   NCS_LIM = (CS_W + 1)'(NUM_CS);

  state_t state_q, state_d;

  logic [DATA_W-1:0] sh, rx_sh, tx_ord, rx_ord;
  logic [DIV_W-1:0]  div_q;
  logic [ECW-1:0]    edge_cnt;
  logic              cpol_q, cpha_q;
  logic              accept, tick, lead_edge, trail_edge;
  logic              last_edge, shift_ev, samp_ev;

  assign accept = (state_q == IDLE) && start
               && ({1'b0, cs_sel} < NCS_LIM);
  assign busy   = (state_q != IDLE);

`ifdef SPI_MASTER_LSB_FIRST_EN
  logic lsb_q;

  function automatic logic [DATA_W-1:0] bit_rev(
    input logic [DATA_W-1:0] v
  );
    for (int i = 0; i < DATA_W; i++) bit_rev[i] = v[DATA_W-1-i];
  endfunction

  // LSB-first is MSB-first on a mirrored word in both directions
  assign tx_ord = lsb_first ? bit_rev(tx_data) : tx_data;
  assign rx_ord = lsb_q ? bit_rev(rx_sh) : rx_sh;

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset)      lsb_q <= 1'b0;
    else if (accept) lsb_q <= lsb_first;
  end
`else
  assign tx_ord = tx_data;
  assign rx_ord = rx_sh;
`endif

  spi_clk_gen #(
    .DIV_W (DIV_W)
  ) u_clk_gen (
    .Pclk       (Pclk),
    .Preset     (Preset),
    .run        (busy),
    .xfer       (state_q == XFER),
    .load       (accept),
    .cpol_in    (mode[CPOL_BIT]),
    .cpol       (cpol_q),
    .div        (div_q),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .sclk       (sclk)
  );

  assign last_edge = (edge_cnt == LAST_E);
  assign shift_ev  = cpha_q ? lead_edge : (trail_edge && !last_edge);
  assign samp_ev   = cpha_q ? trail_edge : lead_edge;

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)             state_d = LEAD;
      LEAD:    if (tick)               state_d = XFER;
      XFER:    if (tick && last_edge)  state_d = TRAIL;
      TRAIL:   if (tick)               state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      sh       <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      done     <= 1'b0;
      div_q    <= DIV_W'(1);
      edge_cnt <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // CPHA=0 presents the first bit now; CPHA=1 waits for the first edge
        sh       <= mode[CPHA_BIT] ? tx_ord : (tx_ord << 1);
        mosi     <= mode[CPHA_BIT] ? 1'b0 : tx_ord[DATA_W-1];
        cs_n     <= ~(NUM_CS'(1) << cs_sel);
        div_q    <= (clk_div == '0) ? DIV_W'(1) : clk_div;
        cpol_q   <= mode[CPOL_BIT];
        cpha_q   <= mode[CPHA_BIT];
        edge_cnt <= '0;
        rx_sh    <= '0;
      end else begin
        if (lead_edge || trail_edge) edge_cnt <= edge_cnt + ECW'(1);
        if (shift_ev) begin
          mosi <= sh[DATA_W-1];
          sh   <= sh << 1;
        end
        if (samp_ev) rx_sh <= {rx_sh[DATA_W-2:0], miso};
        if (state_q == TRAIL && tick) begin
          rx_data <= rx_ord;
          done    <= 1'b1;
          cs_n    <= '1;
          mosi    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_gen2.sv
// tb_spi_master_gen2: directed checks of spi_master_gen2 against loopback
// and a behavioural SPI slave; build with SPI_MASTER_LSB_FIRST_EN for bit order.
module tb_spi_master_gen2;

  logic       Pclk = 1'b0;
  logic       Preset = 1'b1;
  logic [7:0] clk_div = 8'd2;
  logic [1:0] mode = 2'd0;
  logic [1:0] cs_sel = 2'd0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       loop = 1'b1;
  logic       miso;
  logic [7:0] rx_data;
  logic       busy, done, sclk, mosi;
  logic [3:0] cs_n;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic       lsb_first = 1'b0;
`endif

  logic [2:0] cs5 = 3'd0;
  logic       start5 = 1'b0;
  logic       miso5 = 1'b0;
  logic [7:0] rx5;
  logic       busy5, done5, sclk5, mosi5;
  logic [4:0] cs_n5;

  always #5 Pclk = ~Pclk;

  spi_master_gen2 u_dut (
    .Pclk (Pclk), .Preset (Preset), .clk_div (clk_div), .mode (mode),
    .cs_sel (cs_sel), .start (start), .tx_data (tx_data),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .rx_data (rx_data), .busy (busy), .done (done), .sclk (sclk),
    .mosi (mosi), .miso (miso), .cs_n (cs_n)
  );

  spi_master_gen2 #(.NUM_CS (5)) u_dut5 (
    .Pclk (Pclk), .Preset (Preset), .clk_div (clk_div), .mode (mode),
    .cs_sel (cs5), .start (start5), .tx_data (tx_data),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .rx_data (rx5), .busy (busy5), .done (done5), .sclk (sclk5),
    .mosi (mosi5), .miso (miso5), .cs_n (cs_n5)
  );

  // behavioural slave: shifts s_resp out, captures mosi into s_rx
  logic       s_cpol = 1'b0, s_cpha = 1'b0, s_miso = 1'b0;
  logic [7:0] s_resp = 8'h00, s_sh = 8'h00, s_rx = 8'h00;
  logic       sel_d = 1'b0;
  wire        sel = ~&cs_n;

  assign miso = loop ? mosi : s_miso;

  always @(negedge Pclk) sel_d = sel;

  always @(posedge sel) begin
    s_sh   = s_resp;
    s_rx   = 8'h00;
    s_miso = 1'b0;
    if (!s_cpha) begin
      s_miso = s_sh[7];
      s_sh   = s_sh << 1;
    end
  end

  always @(sclk) begin
    if (sel && sel_d) begin
      if (sclk !== s_cpol) begin
        if (s_cpha) begin
          s_miso = s_sh[7];
          s_sh   = s_sh << 1;
        end else s_rx = {s_rx[6:0], mosi};
      end else begin
        if (s_cpha) s_rx = {s_rx[6:0], mosi};
        else begin
          s_miso = s_sh[7];
          s_sh   = s_sh << 1;
        end
      end
    end
  end

  int nrise = 0, nedge = 0, ndone = 0, ndone5 = 0;
  always @(posedge sclk) nrise++;
  always @(sclk) nedge++;
  always @(posedge Pclk) if (done === 1'b1) ndone++;
  always @(posedge Pclk) if (done5 === 1'b1) ndone5++;

  int nvec = 0, nbad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Pclk);
    #1;
  endtask

  // Starts a transfer now; returns in the done cycle (or at the bound).
  task automatic xfer(input logic [7:0] d, input logic [1:0] m,
                      input logic [1:0] cs, input logic [7:0] dv,
                      output int cyc, output logic [3:0] cs0,
                      output logic sclk0, output logic busy0,
                      output logic mosi0, output logic [7:0] rx0);
    tx_data = d; mode = m; cs_sel = cs; clk_div = dv;
    s_cpol = m[1]; s_cpha = m[0];
    start = 1'b1;
    step(1);
    start = 1'b0;
    cs0 = cs_n; sclk0 = sclk; busy0 = busy; mosi0 = mosi; rx0 = rx_data;
    cyc = 1;
    while (done !== 1'b1 && cyc < 2000) begin
      step(1);
      cyc++;
    end
  endtask

  int         cyc, nd0, ne0, nr0;
  logic [3:0] cs0;
  logic [7:0] rx0;
  logic       sclk0, busy0, mosi0;

  initial begin
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rx", rx_data, 8'h00);
    Preset = 1'b0;
    step(2);

    // mode 0, div 2, loopback A5
    loop = 1'b1; nr0 = nrise;
    xfer(8'hA5, 2'd0, 2'd0, 8'd2, cyc, cs0, sclk0, busy0, mosi0, rx0);
    chk("m0_cyc", cyc, 37);
    chk("m0_rx", rx_data, 8'hA5);
    chk("m0_rise", nrise - nr0, 8);
    chk("m0_cs", cs0, 4'b1110);
    chk("m0_busy", busy0, 1);
    chk("m0_mosi0", mosi0, 1);
    chk("m0_end_busy", busy, 0);
    chk("m0_end_cs", cs_n, 4'hF);
    chk("m0_end_mosi", mosi, 0);

    // mode 3, div 1, slave returns C3; started in the done cycle
    loop = 1'b0; s_resp = 8'hC3;
    xfer(8'h3C, 2'd3, 2'd0, 8'd1, cyc, cs0, sclk0, busy0, mosi0, rx0);
    chk("m3_b2b_busy", busy0, 1);
    chk("m3_cyc", cyc, 19);
    chk("m3_rx", rx_data, 8'hC3);
    chk("m3_hold_rx", rx0, 8'hA5);
    chk("m3_sclk_idle", sclk0, 1);
    chk("m3_sclk_end", sclk, 1);
    chk("m3_cs", cs0, 4'b1110);
    chk("m3_slave_rx", s_rx, 8'h3C);
    step(2);

    // mode 1, cs 2, div 3
    s_resp = 8'h5E;
    xfer(8'h81, 2'd1, 2'd2, 8'd3, cyc, cs0, sclk0, busy0, mosi0, rx0);
    chk("m1_cyc", cyc, 55);
    chk("m1_cs", cs0, 4'b1011);
    chk("m1_rx", rx_data, 8'h5E);
    chk("m1_slave_rx", s_rx, 8'h81);
    step(2);

    // mode 2, cs 2, div 2
    s_resp = 8'h96;
    xfer(8'h81, 2'd2, 2'd2, 8'd2, cyc, cs0, sclk0, busy0, mosi0, rx0);
    chk("m2_cyc", cyc, 37);
    chk("m2_cs", cs0, 4'b1011);
    chk("m2_sclk_idle", sclk0, 1);
    chk("m2_mosi0", mosi0, 1);
    chk("m2_rx", rx_data, 8'h96);
    chk("m2_slave_rx", s_rx, 8'h81);
    step(2);

    // start while busy is ignored; exactly one done
    loop = 1'b1; nd0 = ndone;
    tx_data = 8'h12; mode = 2'd0; cs_sel = 2'd1; clk_div = 8'd2;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    tx_data = 8'hFF; mode = 2'd3; cs_sel = 2'd3; clk_div = 8'd1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("busy_cs", cs_n, 4'b1101);
    cyc = 7;
    while (done !== 1'b1 && cyc < 2000) begin
      step(1);
      cyc++;
    end
    chk("busy_cyc", cyc, 37);
    chk("busy_rx", rx_data, 8'h12);
    step(45);
    chk("busy_ndone", ndone - nd0, 1);

    // out-of-range chip select on a 5-slave instance
    cs5 = 3'd5; start5 = 1'b1;
    step(1);
    start5 = 1'b0;
    step(2);
    chk("cs5_busy", busy5, 0);
    chk("cs5_cs_n", cs_n5, 5'h1F);
    chk("cs5_ndone", ndone5, 0);
    cs5 = 3'd4; start5 = 1'b1;
    step(1);
    start5 = 1'b0;
    chk("cs4_busy", busy5, 1);
    chk("cs4_cs_n", cs_n5, 5'b01111);

    // reset at the 5th sclk edge
    tx_data = 8'h77; mode = 2'd0; cs_sel = 2'd0; clk_div = 8'd2;
    start = 1'b1;
    step(1);
    start = 1'b0;
    ne0 = nedge; cyc = 0;
    while (nedge - ne0 < 5 && cyc < 200) begin
      step(1);
      cyc++;
    end
    chk("rst5_edges", nedge - ne0, 5);
    nd0 = ndone;
    Preset = 1'b1;
    step(1);
    chk("rst5_cs", cs_n, 4'hF);
    chk("rst5_busy", busy, 0);
    chk("rst5_sclk", sclk, 0);
    chk("rst5_mosi", mosi, 0);
    chk("rst5_rx", rx_data, 8'h00);
    Preset = 1'b0;
    step(45);
    chk("rst5_ndone", ndone - nd0, 0);

    xfer(8'h5A, 2'd0, 2'd0, 8'd2, cyc, cs0, sclk0, busy0, mosi0, rx0);
    chk("fresh_cyc", cyc, 37);
    chk("fresh_rx", rx_data, 8'h5A);

    // clk_div 0 behaves as 1
    xfer(8'hC6, 2'd0, 2'd1, 8'd0, cyc, cs0, sclk0, busy0, mosi0, rx0);
    chk("div0_cyc", cyc, 19);
    chk("div0_cs", cs0, 4'b1101);
    chk("div0_rx", rx_data, 8'hC6);
    step(2);

`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_first = 1'b1;
    xfer(8'h01, 2'd0, 2'd0, 8'd2, cyc, cs0, sclk0, busy0, mosi0, rx0);
    chk("lsb_mosi0", mosi0, 1);
    chk("lsb_rx", rx_data, 8'h01);
    lsb_first = 1'b0;
    step(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
